// File: rtl/aes_gcm_pkg.sv
// Shared definitions for the AES-GCM round stage.
// Contents:
//   RK_W, NUM_RK, KS_W  round-key slice width, round-key count, key-schedule width
//   occ_e               occupancy of the output/skid register pair
//   sbox()              AES forward S-box lookup
//   xtime()             multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1
package aes_gcm_pkg;

  localparam int RK_W   = 128;
  localparam int NUM_RK = 11;
  localparam int KS_W   = RK_W * NUM_RK;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

  // Byte 0x00 sits in the most significant byte, so entry b lives at index 255-b.
  localparam logic [255:0][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[8'hFF - b];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_round.sv
// One combinational AES encryption round (SubBytes, ShiftRows, MixColumns,
// AddRoundKey). MixColumns is skipped when final_round is set.
// Ports:
//   state        in   128  round input, byte 0 in bits [127:120], column-major
//   round_key    in   128  key added at the end of the round
//   final_round  in   1    1 = last round (no MixColumns)
//   round_out    out  128  round result
module aes_round
  import aes_gcm_pkg::*;
(
  input  logic [127:0] state,
  input  logic [127:0] round_key,
  input  logic         final_round,
  output logic [127:0] round_out
);

  logic [127:0] sub_w;
  logic [127:0] shf_w;
  logic [127:0] mix_w;

  function automatic logic [31:0] mix_col(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  always_comb begin
    sub_w = '0;
    shf_w = '0;
    mix_w = '0;
    for (int i = 0; i < 16; i++) begin
      sub_w[127-8*i -: 8] = sbox(state[127-8*i -: 8]);
    end
    // Row r of column c takes the byte from column (c+r) mod 4.
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        shf_w[127-8*(4*c+r) -: 8] = sub_w[127-8*(4*((c+r)%4)+r) -: 8];
      end
    end
    for (int c = 0; c < 4; c++) begin
      mix_w[127-32*c -: 32] = mix_col(shf_w[127-32*c -: 32]);
    end
  end

  assign round_out = (final_round ? shf_w : mix_w) ^ round_key;

endmodule

// File: rtl/aes_gcm_round_stage.sv
// Pipeline stage applying NUM_ROUNDS consecutive AES-128 rounds, starting at
// FIRST_ROUND, to each enabled lane, with a two-entry (main + skid) output
// buffer so o_ready is a plain flop independent of i_ready.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   i_valid / o_ready           upstream handshake
//   i_state, i_lane_en          lane states (lane 0 = MS slice) and enables (lane 0 = MS bit)
//   i_key_schedule, i_sideband  round keys 0..10 (key 0 = MS slice), opaque side data
//   o_valid / i_ready           downstream handshake
//   o_state, o_lane_en, o_key_schedule, o_sideband  registered beat
//   o_stall_cnt                 saturating count of cycles with o_valid=1, i_ready=0
//
// state     | meaning
// OCC_EMPTY | no beat held, o_valid=0, o_ready=1
// OCC_ONE   | one beat in main register, o_valid=1, o_ready=1
// OCC_FULL  | main and skid both hold beats, o_valid=1, o_ready=0
module aes_gcm_round_stage
  import aes_gcm_pkg::*;
#(
  parameter int NUM_LANES   = 3,
  parameter int FIRST_ROUND = 1,
  parameter int NUM_ROUNDS  = 1,
  parameter int SIDEBAND_W  = 385
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_valid,
  output logic                      o_ready,
  input  logic [NUM_LANES*RK_W-1:0] i_state,
  input  logic [NUM_LANES-1:0]      i_lane_en,
  input  logic [KS_W-1:0]           i_key_schedule,
  input  logic [SIDEBAND_W-1:0]     i_sideband,
  output logic                      o_valid,
  input  logic                      i_ready,
  output logic [NUM_LANES*RK_W-1:0] o_state,
  output logic [NUM_LANES-1:0]      o_lane_en,
  output logic [KS_W-1:0]           o_key_schedule,
  output logic [SIDEBAND_W-1:0]     o_sideband,
  output logic [15:0]               o_stall_cnt
);

  localparam int ST_W = NUM_LANES * RK_W;
  localparam int PW   = ST_W + NUM_LANES + KS_W + SIDEBAND_W;

  if (FIRST_ROUND < 0 || NUM_ROUNDS < 1 || FIRST_ROUND + NUM_ROUNDS - 1 > NUM_RK - 1) begin : g_bad_cfg
    $error("aes_gcm_round_stage: rounds %0d..%0d out of range 0..10",
           FIRST_ROUND, FIRST_ROUND + NUM_ROUNDS - 1);
  end

  logic [RK_W-1:0] lane_chain [NUM_LANES][NUM_ROUNDS+1];
  logic [ST_W-1:0] xform_state;

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    assign lane_chain[l][0] = i_state[(NUM_LANES-1-l)*RK_W +: RK_W];
    for (genvar j = 0; j < NUM_ROUNDS; j++) begin : g_rnd
      localparam int RND = FIRST_ROUND + j;
      logic [RK_W-1:0] rk;
      logic [RK_W-1:0] rnd_out;
      assign rk = i_key_schedule[(NUM_RK-1-RND)*RK_W +: RK_W];
      aes_round u_round (
        .state       (lane_chain[l][j]),
        .round_key   (rk),
        .final_round (RND == NUM_RK - 1),
        .round_out   (rnd_out)
      );
      // Round 0 is the initial key whitening only.
      assign lane_chain[l][j+1] = (RND == 0) ? (lane_chain[l][j] ^ rk) : rnd_out;
    end
    assign xform_state[(NUM_LANES-1-l)*RK_W +: RK_W] =
      i_lane_en[NUM_LANES-1-l] ? lane_chain[l][NUM_ROUNDS] : lane_chain[l][0];
  end

  logic [PW-1:0] in_payload;
  logic [PW-1:0] main_q;
  logic [PW-1:0] skid_q;
  occ_e          occ_q;
  occ_e          occ_d;
  logic          accept;
  logic          drain;
  logic          load_main;
  logic          load_skid;
  logic          skid_to_main;

  assign in_payload = {xform_state, i_lane_en, i_key_schedule, i_sideband};
  assign accept     = i_valid & o_ready;
  assign drain      = o_valid & i_ready;

  always_comb begin
    occ_d        = occ_q;
    load_main    = 1'b0;
    load_skid    = 1'b0;
    skid_to_main = 1'b0;
    case (occ_q)
      OCC_EMPTY: begin
        if (accept) begin
          occ_d     = OCC_ONE;
          load_main = 1'b1;
        end
      end
      OCC_ONE: begin
        if (accept && drain) begin
          load_main = 1'b1;
        end else if (accept) begin
          occ_d     = OCC_FULL;
          load_skid = 1'b1;
        end else if (drain) begin
          occ_d = OCC_EMPTY;
        end
      end
      OCC_FULL: begin
        if (drain) begin
          occ_d        = OCC_ONE;
          skid_to_main = 1'b1;
        end
      end
      default: occ_d = OCC_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q       <= OCC_EMPTY;
      o_valid     <= 1'b0;
      o_ready     <= 1'b1;
      o_stall_cnt <= 16'h0000;
    end else begin
      occ_q   <= occ_d;
      o_valid <= (occ_d != OCC_EMPTY);
      o_ready <= (occ_d != OCC_FULL);
      if (o_valid && !i_ready && o_stall_cnt != 16'hFFFF) begin
        o_stall_cnt <= o_stall_cnt + 16'd1;
      end
    end
  end

  // Data registers carry no reset; their contents only matter while o_valid=1.
  always_ff @(posedge clk) begin
    if (load_main) begin
      main_q <= in_payload;
    end else if (skid_to_main) begin
      main_q <= skid_q;
    end
    if (load_skid) begin
      skid_q <= in_payload;
    end
  end

  assign {o_state, o_lane_en, o_key_schedule, o_sideband} = main_q;

endmodule

// File: tb/tb_aes_gcm_round_stage.sv
module tb_aes_gcm_round_stage;

  localparam int NL   = 3;
  localparam int SB_W = 385;
  localparam int KS_W = 1408;
  localparam int FR   = 1;
  localparam int NR   = 1;

  localparam logic [127:0] S1      = 128'h00102030405060708090a0b0c0d0e0f0;
  localparam logic [127:0] S1_OUT  = 128'h89d810e8855ace682d1843d8cb128fe4;
  localparam logic [127:0] S10     = 128'hbd6e7c3df2b5779e0b61216e8b10b689;
  localparam logic [127:0] S10_OUT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] RK10    = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic              i_valid;
  logic              o_ready;
  logic [NL*128-1:0] i_state;
  logic [NL-1:0]     i_lane_en;
  logic [KS_W-1:0]   i_key_schedule;
  logic [SB_W-1:0]   i_sideband;
  logic              o_valid;
  logic              i_ready;
  logic [NL*128-1:0] o_state;
  logic [NL-1:0]     o_lane_en;
  logic [KS_W-1:0]   o_key_schedule;
  logic [SB_W-1:0]   o_sideband;
  logic [15:0]       o_stall_cnt;

  aes_gcm_round_stage #(
    .NUM_LANES(NL), .FIRST_ROUND(FR), .NUM_ROUNDS(NR), .SIDEBAND_W(SB_W)
  ) u_dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_state(i_state), .i_lane_en(i_lane_en), .i_key_schedule(i_key_schedule),
    .i_sideband(i_sideband), .o_valid(o_valid), .i_ready(i_ready),
    .o_state(o_state), .o_lane_en(o_lane_en), .o_key_schedule(o_key_schedule),
    .o_sideband(o_sideband), .o_stall_cnt(o_stall_cnt)
  );

  // Final-round instance, single lane.
  logic          r10_valid;
  logic [127:0]  r10_state;
  logic          r10_o_ready;
  logic          r10_o_valid;
  logic [127:0]  r10_o_state;
  logic [0:0]    r10_o_en;
  logic [KS_W-1:0] r10_o_ks;
  logic [7:0]    r10_o_sb;
  logic [15:0]   r10_o_stall;
  logic [KS_W-1:0] ks_c1;

  aes_gcm_round_stage #(
    .NUM_LANES(1), .FIRST_ROUND(10), .NUM_ROUNDS(1), .SIDEBAND_W(8)
  ) u_dut_r10 (
    .clk(clk), .rst(rst), .i_valid(r10_valid), .o_ready(r10_o_ready),
    .i_state(r10_state), .i_lane_en(1'b1), .i_key_schedule(ks_c1),
    .i_sideband(8'h00), .o_valid(r10_o_valid), .i_ready(1'b1),
    .o_state(r10_o_state), .o_lane_en(r10_o_en), .o_key_schedule(r10_o_ks),
    .o_sideband(r10_o_sb), .o_stall_cnt(r10_o_stall)
  );

  typedef struct packed {
    logic [NL*128-1:0] st;
    logic [NL-1:0]     en;
    logic [KS_W-1:0]   ks;
    logic [SB_W-1:0]   sb;
  } beat_t;

  beat_t       mq[$];
  int unsigned m_stall;
  int unsigned n_vec = 0;
  int unsigned n_bad = 0;
  logic [7:0]  sb_tab [256];
  logic [127:0] rk [11];

  // ---------------- reference AES from GF(2^8) arithmetic ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return 8'((v << n) | (v >> (8 - n)));
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      if (x != 0) begin
        for (int y = 1; y < 256; y++) begin
          if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
        end
      end
      sb_tab[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic expand_key(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb_tab[t[31:24]], sb_tab[t[23:16]], sb_tab[t[15:8]], sb_tab[t[7:0]]};
        t = t ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) begin
      rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      ks_c1[(10-r)*128 +: 128] = rk[r];
    end
  endtask

  function automatic logic [127:0] m_round(input logic [127:0] s, input logic [127:0] k, input int r);
    logic [7:0]   a [16];
    logic [7:0]   b [16];
    logic [127:0] o;
    if (r == 0) return s ^ k;
    for (int i = 0; i < 16; i++) a[i] = sb_tab[s[127-8*i -: 8]];
    for (int c = 0; c < 4; c++)
      for (int row = 0; row < 4; row++)
        b[4*c+row] = a[4*((c+row)%4)+row];
    if (r != 10) begin
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++)
          a[4*c+row] = gmul(8'h02, b[4*c+row]) ^ gmul(8'h03, b[4*c+(row+1)%4]) ^
                       b[4*c+(row+2)%4] ^ b[4*c+(row+3)%4];
      b = a;
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = b[i];
    return o ^ k;
  endfunction

  function automatic beat_t model_beat(input beat_t in);
    beat_t        out;
    logic [127:0] s;
    out = in;
    for (int l = 0; l < NL; l++) begin
      if (in.en[NL-1-l]) begin
        s = in.st[(NL-1-l)*128 +: 128];
        for (int r = FR; r < FR + NR; r++) s = m_round(s, in.ks[(10-r)*128 +: 128], r);
        out.st[(NL-1-l)*128 +: 128] = s;
      end
    end
    return out;
  endfunction

  // ---------------- checking ----------------
  task automatic chk(input string nm, input logic [KS_W-1:0] act, input logic [KS_W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      int ch;
      ch = 0;
      n_bad++;
      for (int c = 0; c < 11; c++) if (act[c*128 +: 128] !== exp[c*128 +: 128]) ch = c;
      $display("FAIL %s word %0d actual %h required %h", nm, ch, act[ch*128 +: 128], exp[ch*128 +: 128]);
    end
  endtask

  task automatic model_check();
    chk("o_ready", o_ready, mq.size() < 2);
    chk("o_valid", o_valid, mq.size() > 0);
    chk("o_stall_cnt", o_stall_cnt, m_stall);
    if (mq.size() > 0) begin
      chk("o_state", o_state, mq[0].st);
      chk("o_lane_en", o_lane_en, mq[0].en);
      chk("o_key_schedule", o_key_schedule, mq[0].ks);
      chk("o_sideband", o_sideband, mq[0].sb);
    end
  endtask

  // One clock: inputs are already driven; update the queue model at the edge,
  // then compare at the following falling edge.
  task automatic cycle(output bit acc);
    bit    dr;
    beat_t nb;
    acc = i_valid && (mq.size() < 2) && !rst;
    dr  = (mq.size() > 0) && i_ready;
    nb  = {i_state, i_lane_en, i_key_schedule, i_sideband};
    @(posedge clk);
    if (rst) begin
      mq.delete();
      m_stall = 0;
    end else begin
      if (mq.size() > 0 && !i_ready && m_stall != 65535) m_stall++;
      if (dr) void'(mq.pop_front());
      if (acc) mq.push_back(model_beat(nb));
    end
    @(negedge clk);
    model_check();
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic beat_t rand_beat();
    beat_t b;
    b.st = {rnd128(), rnd128(), rnd128()};
    b.en = 3'($urandom_range(0, 7));
    b.ks = ks_c1;
    b.sb = {rnd128(), rnd128(), rnd128(), 1'($urandom_range(0, 1))};
    return b;
  endfunction

  task automatic drive(input beat_t b);
    {i_state, i_lane_en, i_key_schedule, i_sideband} = b;
  endtask

  initial begin
    bit           acc;
    beat_t        ba, bb, bc;
    logic [NL*128-1:0] held;
    int unsigned  accepted;
    int unsigned  cyc;

    rst = 1'b1; i_valid = 1'b0; i_ready = 1'b1;
    i_state = '0; i_lane_en = '0; i_key_schedule = '0; i_sideband = '0;
    r10_valid = 1'b0; r10_state = '0; ks_c1 = '0; m_stall = 0;
    build_sbox();
    expand_key(128'h000102030405060708090a0b0c0d0e0f);

    // Model pins against published vectors.
    chk("model_rk10", rk[10], RK10);
    chk("model_round1", m_round(S1, rk[1], 1), S1_OUT);
    chk("model_round10", m_round(S10, rk[10], 10), S10_OUT);

    // Reset state.
    cycle(acc);
    cycle(acc);
    rst = 1'b0;
    chk("reset_valid", o_valid, 1'b0);
    chk("reset_ready", o_ready, 1'b1);
    chk("reset_stall", o_stall_cnt, 16'd0);

    // Test 1: round 1 on all lanes, one-cycle latency.
    drive({{S1, S1, S1}, 3'b111, ks_c1, {SB_W{1'b1}}});
    i_valid = 1'b1;
    cycle(acc);
    i_valid = 1'b0;
    chk("t1_valid", o_valid, 1'b1);
    chk("t1_lane0", o_state[383:256], S1_OUT);
    chk("t1_lane2", o_state[127:0], S1_OUT);

    // Test 2: final round, no MixColumns.
    r10_state = S10;
    r10_valid = 1'b1;
    cycle(acc);
    r10_valid = 1'b0;
    chk("t2_valid", r10_o_valid, 1'b1);
    chk("t2_state", r10_o_state, S10_OUT);

    // Test 3: lane 1 bypassed.
    drive({{S1, S1, S1}, 3'b101, ks_c1, {SB_W{1'b0}}});
    i_valid = 1'b1;
    cycle(acc);
    i_valid = 1'b0;
    chk("t3_lane0", o_state[383:256], S1_OUT);
    chk("t3_lane1", o_state[255:128], S1);
    chk("t3_lane2", o_state[127:0], S1_OUT);
    chk("t3_lane_en", o_lane_en, 3'b101);
    cycle(acc);
    cycle(acc);

    // Test 4: downstream stalled for five valid cycles.
    ba = rand_beat(); bb = rand_beat(); bc = rand_beat();
    i_ready = 1'b0;
    i_valid = 1'b1;
    drive(ba);
    cycle(acc);
    drive(bb);
    cycle(acc);
    chk("t4_ready_low", o_ready, 1'b0);
    held = o_state;
    chk("t4_head_is_a", held, model_beat(ba).st);
    drive(bc);
    for (int k = 0; k < 4; k++) begin
      cycle(acc);
      chk("t4_hold", o_state, held);
    end
    chk("t4_stall_cnt", o_stall_cnt, 16'd5);
    i_valid = 1'b0;
    i_ready = 1'b1;
    cycle(acc);
    chk("t4_second_is_b", o_state, model_beat(bb).st);
    cycle(acc);
    chk("t4_drained", o_valid, 1'b0);

    // Test 6: reset while FULL, with accept and drain requested at the same edge.
    i_ready = 1'b0;
    i_valid = 1'b1;
    drive(rand_beat());
    cycle(acc);
    drive(rand_beat());
    cycle(acc);
    chk("t6_full", o_ready, 1'b0);
    rst = 1'b1;
    i_ready = 1'b1;
    cycle(acc);
    rst = 1'b0;
    i_valid = 1'b0;
    chk("t6_valid", o_valid, 1'b0);
    chk("t6_ready", o_ready, 1'b1);
    chk("t6_stall", o_stall_cnt, 16'd0);

    // Test 5: random handshakes over 10000 accepted beats.
    accepted = 0;
    cyc = 0;
    drive(rand_beat());
    while (accepted < 10000 && cyc < 40000) begin
      i_valid = ($urandom_range(0, 3) != 0);
      i_ready = ($urandom_range(0, 3) != 0);
      cycle(acc);
      cyc++;
      if (acc) begin
        accepted++;
        drive(rand_beat());
      end
    end
    chk("t5_beats", accepted, 10000);
    i_valid = 1'b0;
    i_ready = 1'b1;
    for (int k = 0; k < 4; k++) cycle(acc);
    chk("t5_empty", o_valid, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
